// File: rtl/uart_report_sched_pkg.sv
// Shared types and defaults for the round-robin UART report scheduler.
package uart_report_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_BUSW        = 32;
  localparam int DEF_TIMEOUT_CYC = 65535;
  localparam int GID_W           = 3;

  // Next round-robin pointer after serving idx; wraps to 0 past the last requester.
  function automatic logic [GID_W-1:0] rr_wrap_inc(input logic [GID_W-1:0] idx,
                                                   input int num_req);
    logic [GID_W:0] s;
    s = {1'b0, idx} + (GID_W+1)'(1);
    return (s == (GID_W+1)'(num_req)) ? '0 : s[GID_W-1:0];
  endfunction

endpackage

// File: rtl/uart_report_sched_if.sv
// Requester and transmitter signal bundle for uart_report_sched.
interface uart_report_sched_if
  import uart_report_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int BUSW    = DEF_BUSW
) ();

  // req[i] is a level held with a stable record until a one-cycle ack[i];
  // uart_en is a one-cycle start pulse and send_flag a one-cycle completion pulse.
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*BUSW-1:0] req_data;
  logic [NUM_REQ-1:0]      ack;
  logic                    uart_en;
  logic [BUSW-1:0]         uart_din;
  logic                    send_flag;
  logic                    busy;
  logic [GID_W-1:0]        grant_id;
  logic                    timeout_err;
  state_t                  dbg_state;

  modport sched (
    input  req, req_data, send_flag,
    output ack, uart_en, uart_din, busy, grant_id, timeout_err, dbg_state
  );

  modport env (
    output req, req_data, send_flag,
    input  ack, uart_en, uart_din, busy, grant_id, timeout_err, dbg_state
  );

endinterface

// File: rtl/uart_report_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module uart_report_sched_rr_pick
  import uart_report_sched_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GID_W-1:0]   i_ptr,
  output logic               o_valid,
  output logic [GID_W-1:0]   o_idx
);

  logic [NUM_REQ-1:0] w_rot;
  logic [GID_W:0]     w_off;
  logic [GID_W:0]     w_sum;

  always_comb begin
    // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
    w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = (GID_W+1)'(k);
    end
    w_sum = {1'b0, i_ptr} + w_off;
    if (w_sum >= (GID_W+1)'(NUM_REQ)) w_sum = w_sum - (GID_W+1)'(NUM_REQ);
    o_valid = |i_req;
    o_idx   = w_sum[GID_W-1:0];
  end

endmodule

// File: rtl/uart_report_sched.sv
// Shares one uart_data transmitter between NUM_REQ latency recorders, round-robin,
// with a watchdog that aborts a transfer whose completion pulse never arrives.
module uart_report_sched
  import uart_report_sched_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int BUSW        = DEF_BUSW,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  uart_report_sched_if.sched        bus
);

  state_t             r_state;
  state_t             w_state_nx;
  logic [GID_W-1:0]   r_ptr;
  logic [GID_W-1:0]   r_gid;
  logic [BUSW-1:0]    r_din;
  logic               r_uart_en;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_busy;
  logic               r_terr;
  logic [15:0]        r_wd;

  logic               w_pick_valid;
  logic [GID_W-1:0]   w_pick_idx;
  logic [BUSW-1:0]    w_pick_data;
  logic [15:0]        w_wd_inc;
  logic               w_wd_expired;
  logic               w_set_terr;
  logic [NUM_REQ-1:0] w_ack_nx;

  uart_report_sched_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_pick_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_pick_idx == GID_W'(j)) w_pick_data = bus.req_data[j*BUSW +: BUSW];
    end
  end

  // r_wd counts cycles elapsed since START, so DONE lands TIMEOUT_CYC cycles after START.
  assign w_wd_inc     = r_wd + 16'd1;
  assign w_wd_expired = (w_wd_inc == 16'(TIMEOUT_CYC));

  always_comb begin
    w_state_nx = r_state;
    w_set_terr = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_pick_valid) w_state_nx = ST_START;
      ST_START: w_state_nx = ST_WAIT;
      ST_WAIT: begin
        if (bus.send_flag) begin
          w_state_nx = ST_DONE;
        end else if (w_wd_expired) begin
          w_state_nx = ST_DONE;
          w_set_terr = 1'b1;
        end
      end
      ST_DONE:  w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
    w_ack_nx = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_ack_nx[j] = (w_state_nx == ST_DONE) && (r_gid == GID_W'(j));
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_gid     <= '0;
      r_din     <= '0;
      r_uart_en <= 1'b0;
      r_ack     <= '0;
      r_busy    <= 1'b0;
      r_terr    <= 1'b0;
      r_wd      <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_uart_en <= (w_state_nx == ST_START);
      r_ack     <= w_ack_nx;
      r_busy    <= (w_state_nx != ST_IDLE);
      if (w_set_terr) r_terr <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_gid <= w_pick_idx;
            r_din <= w_pick_data;
          end
        end
        ST_START: r_wd  <= 16'd1;
        ST_WAIT:  r_wd  <= w_wd_inc;
        ST_DONE:  r_ptr <= rr_wrap_inc(r_gid, NUM_REQ);
        default:  r_wd  <= r_wd;
      endcase
    end
  end

  assign bus.ack         = r_ack;
  assign bus.uart_en     = r_uart_en;
  assign bus.uart_din    = r_din;
  assign bus.busy        = r_busy;
  assign bus.grant_id    = r_gid;
  assign bus.timeout_err = r_terr;
  assign bus.dbg_state   = r_state;

endmodule
